// File: rtl/axi_reg_pkg.sv
// axi_reg_pkg: shared response codes and enums for the AXI4-Lite register bridge.
package axi_reg_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [2:0] {IDLE, WACC, WRESP, RACC, RRESP} bridge_state_e;
    typedef enum logic {PRIO_WRITE, PRIO_READ} prio_e;
endpackage

// File: rtl/axi_lite_reg_bridge.sv
// axi_lite_reg_bridge: AXI4-Lite slave to one-cycle register-port strobe bridge.
// Optional address range check enabled by AXI_LITE_REG_BRIDGE_RANGE_CHECK_EN.
module axi_lite_reg_bridge
    import axi_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = 'h800
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [ID_WIDTH-1:0]     aw_id_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [1:0]              b_resp_o,
    output logic [ID_WIDTH-1:0]     b_id_o,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [ID_WIDTH-1:0]     ar_id_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic [ID_WIDTH-1:0]     r_id_o,
    output logic                    r_last_o,
    output logic [ADDR_WIDTH-1:0]   address_o,
    output logic                    en_o,
    output logic                    we_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    input  logic [DATA_WIDTH-1:0]   data_i
);
`ifdef AXI_LITE_REG_BRIDGE_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    bridge_state_e         state_q, state_d;
    prio_e                 prio_q, prio_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d, ar_id_q, ar_id_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d, r_data_q, r_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic [1:0]            resp_q, resp_d;
    logic                  idle, acc, range_err, aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] acc_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ((aw_hs | aw_held_q) & (w_hs | w_held_q)) ? WACC : ar_hs ? RACC : IDLE;
            WACC:    state_d = WRESP;
            WRESP:   state_d = b_ready_i ? IDLE : WRESP;
            RACC:    state_d = RRESP;
            RRESP:   state_d = r_ready_i ? IDLE : RRESP;
            default: state_d = IDLE;
        endcase
    end

    // Readys may look at the other channel's valid; valids only ever follow state.
    always_comb begin
        idle       = state_q == IDLE;
        aw_ready_o = idle & !aw_held_q & !(ar_valid_i & (prio_q == PRIO_READ) & !w_held_q);
        w_ready_o  = idle & !w_held_q & !(ar_valid_i & (prio_q == PRIO_READ) & !aw_held_q);
        ar_ready_o = idle & !aw_held_q & !w_held_q & !(aw_valid_i & (prio_q == PRIO_WRITE));
        aw_hs      = aw_valid_i & aw_ready_o;
        w_hs       = w_valid_i & w_ready_o;
        ar_hs      = ar_valid_i & ar_ready_o;
        acc        = (state_q == WACC) | (state_q == RACC);
        acc_addr   = (state_q == WACC) ? aw_addr_q : (state_q == RACC) ? ar_addr_q : '0;
        range_err  = RANGE_CHECK && (acc_addr >= ADDR_SPAN);
        en_o       = acc & !range_err;
        we_o       = en_o & (state_q == WACC);
        address_o  = acc_addr;
        data_o     = (state_q == WACC) ? w_data_q : '0;
        be_o       = (state_q == WACC) ? w_strb_q : '0;
        b_valid_o  = state_q == WRESP;
        b_id_o     = aw_id_q;
        b_resp_o   = resp_q;
        r_valid_o  = state_q == RRESP;
        r_id_o     = ar_id_q;
        r_data_o   = r_data_q;
        r_resp_o   = resp_q;
        r_last_o   = 1'b1;
    end

    always_comb begin
        aw_held_d = (state_q == WRESP && b_ready_i) ? 1'b0 : aw_held_q | aw_hs;
        w_held_d  = (state_q == WRESP && b_ready_i) ? 1'b0 : w_held_q | w_hs;
        aw_addr_d = aw_hs ? aw_addr_i : aw_addr_q;
        aw_id_d   = aw_hs ? aw_id_i : aw_id_q;
        w_data_d  = w_hs ? w_data_i : w_data_q;
        w_strb_d  = w_hs ? w_strb_i : w_strb_q;
        ar_addr_d = ar_hs ? ar_addr_i : ar_addr_q;
        ar_id_d   = ar_hs ? ar_id_i : ar_id_q;
        r_data_d  = (state_q == RACC) ? (range_err ? '0 : data_i) : r_data_q;
        resp_d    = acc ? (range_err ? RESP_SLVERR : RESP_OKAY) : resp_q;
        prio_d    = (state_q == WACC) ? PRIO_READ : (state_q == RACC) ? PRIO_WRITE : prio_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= PRIO_WRITE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_addr_q <= '0;
            ar_id_q   <= '0;
            r_data_q  <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            prio_q    <= prio_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            aw_id_q   <= aw_id_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_addr_q <= ar_addr_d;
            ar_id_q   <= ar_id_d;
            r_data_q  <= r_data_d;
            resp_q    <= resp_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// tb_axi_lite_reg_bridge: directed table plus corner sequences for axi_lite_reg_bridge.
module tb_axi_lite_reg_bridge;
`ifdef AXI_LITE_REG_BRIDGE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, b_valid_o, b_ready_i;
    logic        ar_valid_i, ar_ready_o, r_valid_o, r_ready_i, r_last_o, en_o, we_o;
    logic [63:0] aw_addr_i, ar_addr_i, w_data_i, r_data_o, address_o, data_o, data_i, rd_val;
    logic [3:0]  aw_id_i, b_id_o, ar_id_i, r_id_o;
    logic [7:0]  w_strb_i, be_o;
    logic [1:0]  b_resp_o, r_resp_o;
    int          checks = 0, errors = 0, en_cnt = 0;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [3:0]  id;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  resp;
        bit          en;
        int          stall;
    } vec_t;
    vec_t vecs[7];

    assign data_i = rd_val;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) if (en_o) en_cnt <= en_cnt + 1;

    axi_lite_reg_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o), .b_id_o(b_id_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i), .ar_id_i(ar_id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
        .r_id_o(r_id_o), .r_last_o(r_last_o),
        .address_o(address_o), .en_o(en_o), .we_o(we_o), .be_o(be_o), .data_o(data_o), .data_i(data_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input string nm, input logic [63:0] addr, input logic [3:0] id, input logic [63:0] data,
                      input logic [7:0] strb, input bit en, input logic [1:0] resp);
        int n = 0;
        aw_addr_i = addr; aw_id_i = id; w_data_i = data; w_strb_i = strb;
        aw_valid_i = 1'b1; w_valid_i = 1'b1;
        #1;
        while (!(aw_ready_o && w_ready_o) && n < 20) begin tick(); n++; end
        chk({nm, "_ready_bound"}, n < 20, 1);
        tick();
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        chk({nm, "_en"}, en_o, en);
        chk({nm, "_we"}, we_o, en);
        chk({nm, "_addr"}, address_o, addr);
        chk({nm, "_data"}, data_o, data);
        chk({nm, "_be"}, be_o, strb);
        tick();
        chk({nm, "_bvalid"}, b_valid_o, 1);
        chk({nm, "_bid"}, b_id_o, id);
        chk({nm, "_bresp"}, b_resp_o, resp);
        chk({nm, "_en_off"}, en_o, 0);
        b_ready_i = 1'b1;
        tick();
        b_ready_i = 1'b0;
        chk({nm, "_bdone"}, b_valid_o, 0);
    endtask

    task automatic rd(input string nm, input logic [63:0] addr, input logic [3:0] id, input logic [63:0] rdata,
                      input bit en, input logic [1:0] resp, input int stall);
        int n = 0;
        logic [63:0] exp_data;
        exp_data = en ? rdata : 64'h0;
        ar_addr_i = addr; ar_id_i = id; rd_val = rdata; ar_valid_i = 1'b1;
        #1;
        while (!ar_ready_o && n < 20) begin tick(); n++; end
        chk({nm, "_ready_bound"}, n < 20, 1);
        tick();
        ar_valid_i = 1'b0;
        chk({nm, "_en"}, en_o, en);
        chk({nm, "_we"}, we_o, 0);
        chk({nm, "_addr"}, address_o, addr);
        tick();
        rd_val = ~rdata;
        chk({nm, "_rvalid"}, r_valid_o, 1);
        chk({nm, "_rdata"}, r_data_o, exp_data);
        chk({nm, "_rid"}, r_id_o, id);
        chk({nm, "_rresp"}, r_resp_o, resp);
        chk({nm, "_rlast"}, r_last_o, 1);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk($sformatf("%s_stall%0d", nm, s), {r_valid_o, r_id_o, r_resp_o, r_data_o[56:0]},
                {1'b1, id, resp, exp_data[56:0]});
        end
        r_ready_i = 1'b1;
        tick();
        r_ready_i = 1'b0;
        chk({nm, "_rdone"}, r_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          np, last, gap_bad, snap, cnt;
        logic [3:0]  we_seq;
        aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0; b_ready_i = 0; r_ready_i = 0;
        aw_addr_i = 0; ar_addr_i = 0; w_data_i = 0; w_strb_i = 0; aw_id_i = 0; ar_id_i = 0; rd_val = 0;
        vecs[0] = '{1'b1, 64'h10,  4'd3,  64'hDEAD_BEEF, 8'hFF, 2'b00, 1'b1, 0};
        vecs[1] = '{1'b0, 64'h18,  4'd5,  64'h1234,      8'h00, 2'b00, 1'b1, 3};
        vecs[2] = '{1'b1, 64'h7F8, 4'd15, '1,            8'h0F, 2'b00, 1'b1, 0};
        vecs[3] = '{1'b0, 64'h0,   4'd0,  '1,            8'h00, 2'b00, 1'b1, 0};
        vecs[4] = '{1'b0, 64'h900, 4'd9,  64'hCAFE,      8'h00, RC ? 2'b10 : 2'b00, !RC, 1};
        vecs[5] = '{1'b1, 64'h800, 4'd1,  64'h55,        8'h01, RC ? 2'b10 : 2'b00, !RC, 0};
        vecs[6] = '{1'b0, 64'h7F8, 4'd2,  64'hA5A5_5A5A, 8'h00, 2'b00, 1'b1, 0};
        tick();
        tick();
        chk("rst_valids", {b_valid_o, r_valid_o, en_o, we_o}, 0);
        chk("rst_addr", address_o, 0);
        chk("rst_wdata", {data_o, be_o}, 0);
        chk("rst_rdata", r_data_o, 0);
        chk("rst_resp_id", {b_resp_o, r_resp_o, b_id_o, r_id_o}, 0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) wr($sformatf("vec%0d", i), vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].strb,
                               vecs[i].en, vecs[i].resp);
            else rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].en,
                    vecs[i].resp, vecs[i].stall);
            tick();
        end

        snap = en_cnt;
        w_data_i = 64'h1111; w_strb_i = 8'h03; w_valid_i = 1'b1;
        #1;
        chk("wfirst_wready", w_ready_o, 1);
        tick();
        w_valid_i = 1'b0;
        chk("wfirst_wheld", w_ready_o, 0);
        chk("wfirst_no_en", en_o, 0);
        tick(); tick(); tick();
        chk("wfirst_no_early_en", en_cnt, snap);
        aw_addr_i = 64'h8; aw_id_i = 4'd6; aw_valid_i = 1'b1;
        #1;
        chk("wfirst_awready", aw_ready_o, 1);
        tick();
        aw_valid_i = 1'b0;
        chk("wfirst_en", {en_o, we_o}, 2'b11);
        chk("wfirst_addr", address_o, 64'h8);
        chk("wfirst_data", {data_o, be_o}, {64'h1111, 8'h03});
        tick();
        chk("wfirst_b", {b_valid_o, b_id_o, b_resp_o}, {1'b1, 4'd6, 2'b00});
        b_ready_i = 1'b1;
        tick();
        b_ready_i = 1'b0;
        chk("wfirst_one_pulse", en_cnt, snap + 1);

        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        aw_addr_i = 64'h20; aw_id_i = 4'd1; w_data_i = 64'h77; w_strb_i = 8'hFF;
        ar_addr_i = 64'h28; ar_id_i = 4'd2; rd_val = 64'h99;
        b_ready_i = 1'b1; r_ready_i = 1'b1;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        np = 0; last = 0; gap_bad = 0; we_seq = 0; cnt = 0;
        for (int c = 0; c < 40 && np < 4; c++) begin
            tick();
            if (b_valid_o && r_valid_o) cnt++;
            if (en_o) begin
                we_seq[np] = we_o;
                if (np > 0 && c - last != 3) gap_bad++;
                last = c;
                np++;
            end
        end
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        chk("arb_count", np, 4);
        chk("arb_order", we_seq, 4'b0101);
        chk("arb_gap", gap_bad, 0);
        chk("arb_overlap", cnt, 0);
        tick(); tick();
        b_ready_i = 1'b0; r_ready_i = 1'b0;

        aw_addr_i = 64'h30; aw_id_i = 4'd7; aw_valid_i = 1'b1; w_valid_i = 1'b1;
        #1;
        tick();
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        tick();
        chk("rstmid_bvalid", b_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rstmid_drop", b_valid_o, 0);
        tick(); tick();
        rst_ni = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b_valid_o || r_valid_o) cnt++;
        end
        chk("rstmid_no_beat", cnt, 0);
        chk("rstmid_idle", {aw_ready_o, w_ready_o}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
